// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl: single-steps a core through its debug clock and dumps
// every debug word (address 0..LAST_ADDR) as bytes over a valid/ready sink,
// closing each dump with a 0x0A terminator.
// Optional build macro DEBUG_SCAN_ADDR_HDR_EN: prefix every word with a
// header byte {1'b0, debug_addr}, giving 5 bytes per address instead of 4.
module debug_scan_ctrl #(
  parameter int STEP_CYC   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int LAST_ADDR  = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_mode,
  input  logic        step_req,
  input  logic        start,
  input  logic [31:0] debug_data,
  input  logic        tx_ready,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [6:0]       ADDR_LAST   = 7'(LAST_ADDR);
`ifdef DEBUG_SCAN_ADDR_HDR_EN
  localparam logic [2:0]       BYTE_LAST   = 3'd4;
`else
  localparam logic [2:0]       BYTE_LAST   = 3'd3;
`endif

  typedef enum logic [3:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    SETTLE,
    LATCH,
    SEND,
    NEXT,
    TERM,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shift_reg;
  logic [2:0]       byte_cnt;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
  logic             hdr_pending;
`endif

  // Whole controller: step sequencing, settle timing, word capture and byte handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      byte_cnt   <= '0;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
      hdr_pending <= 1'b0;
`endif
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      debug_en <= dbg_mode;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (step_req && debug_en) begin
            state      <= STEP_HI;
            debug_step <= 1'b1;
            cnt        <= '0;
            busy       <= 1'b1;
          end else if (step_req || start) begin
            state      <= SETTLE;
            debug_addr <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
          end
        end
        STEP_HI: begin
          if (cnt == STEP_LAST) begin
            state      <= STEP_LO;
            debug_step <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STEP_LO: begin
          if (cnt == STEP_LAST) begin
            state      <= SETTLE;
            debug_addr <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= LATCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          shift_reg <= debug_data;
          byte_cnt  <= '0;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
          hdr_pending <= 1'b1;
`endif
          state     <= SEND;
        end
        SEND: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
            tx_data  <= hdr_pending ? {1'b0, debug_addr} : shift_reg[31:24];
`else
            tx_data  <= shift_reg[31:24];
`endif
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
            if (hdr_pending) begin
              hdr_pending <= 1'b0;
            end else begin
              shift_reg <= {shift_reg[23:0], 8'h00};
            end
`else
            shift_reg <= {shift_reg[23:0], 8'h00};
`endif
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == BYTE_LAST) begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (debug_addr == ADDR_LAST) begin
            state <= TERM;
          end else begin
            debug_addr <= debug_addr + 7'd1;
            cnt        <= '0;
            state      <= SETTLE;
          end
        end
        TERM: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h0A;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// tb_debug_scan_ctrl: table-driven IDLE decisions, hand-written corner
// sequences and randomized dumps compared against a byte-stream model
// built directly from the memory image the bench presents to the DUT.
module tb_debug_scan_ctrl;

  localparam int LAST = 63;
`ifdef DEBUG_SCAN_ADDR_HDR_EN
  localparam int BPA = 5;
`else
  localparam int BPA = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dbg_mode = 1'b0;
  logic        step_req = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] debug_data;
  logic        debug_en;
  logic        debug_step;
  logic [6:0]  debug_addr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:127];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  bit          ready_force_en = 1'b1;
  bit          ready_force = 1'b1;
  int unsigned ready_pct = 100;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  typedef struct {
    bit mode;
    bit st;
    bit sp;
    bit exp_step;
    bit exp_busy;
  } vec_t;

  vec_t vecs [6];

  debug_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_mode   (dbg_mode),
    .step_req   (step_req),
    .start      (start),
    .debug_data (debug_data),
    .tx_ready   (tx_ready),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .done       (done)
  );

  // Core model: the word returned depends only on the current debug address
  assign debug_data = mem[debug_addr];

  // Free-running clock
  always #5 clk = ~clk;

  // Sink readiness, either forced or random, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    if (ready_force_en) tx_ready = ready_force;
    else tx_ready = ($urandom_range(99, 0) < ready_pct);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Byte collector and handshake-hold checker, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", tx_valid, 1);
        checkOutput("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic applyStimulus(input bit s, input bit p);
    @(posedge clk);
    #2;
    start = s;
    step_req = p;
    @(posedge clk);
    #2;
    start = 1'b0;
    step_req = 1'b0;
  endtask

  task automatic setMode(input bit m);
    @(posedge clk);
    #2;
    dbg_mode = m;
    repeat (2) @(posedge clk);
  endtask

  task automatic fillMem();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  task automatic buildExpected();
    exp_q.delete();
    for (int a = 0; a <= LAST; a++) begin
`ifdef DEBUG_SCAN_ADDR_HDR_EN
      exp_q.push_back({1'b0, 7'(a)});
`endif
      for (int b = 3; b >= 0; b--) exp_q.push_back(mem[a][8*b +: 8]);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic checkResetOuts(input string name);
    checkOutput(name, {12'h0, debug_en, debug_step, debug_addr, tx_data, tx_valid, busy, done}, 0);
  endtask

  task automatic waitDone(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({name, "_finished"}, ok, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compareDump(input string name);
    int n;
    checkOutput({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    checkOutput({name, "_done_pulses"}, done_cnt, 1);
    checkOutput({name, "_addr_hold"}, debug_addr, LAST);
    checkOutput({name, "_idle"}, busy, 0);
  endtask

  task automatic beginDump();
    buildExpected();
    got_q.delete();
    done_cnt = 0;
  endtask

  // Hard bound on total run time
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int hi;
    int lo;
    int idx;
    bit seen;
    logic [7:0] held;
    logic [31:0] word5;

    vecs[0] = '{mode: 0, st: 0, sp: 0, exp_step: 0, exp_busy: 0};
    vecs[1] = '{mode: 0, st: 1, sp: 0, exp_step: 0, exp_busy: 1};
    vecs[2] = '{mode: 0, st: 0, sp: 1, exp_step: 0, exp_busy: 1};
    vecs[3] = '{mode: 1, st: 1, sp: 1, exp_step: 1, exp_busy: 1};
    vecs[4] = '{mode: 1, st: 0, sp: 1, exp_step: 1, exp_busy: 1};
    vecs[5] = '{mode: 1, st: 1, sp: 0, exp_step: 0, exp_busy: 1};

    fillMem();
    #3;
    checkResetOuts("reset_initial");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // IDLE decision table; each started operation is abandoned by reset
    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #2 dbg_mode = vecs[v].mode;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_debug_en", v), debug_en, vecs[v].mode);
      applyStimulus(vecs[v].st, vecs[v].sp);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      checkOutput($sformatf("vec%0d_step", v), debug_step, vecs[v].exp_step);
      checkOutput($sformatf("vec%0d_addr", v), debug_addr, 0);
      #1 rst = 1'b0;
      #1 checkResetOuts($sformatf("vec%0d_reset", v));
      @(posedge clk);
      #2 rst = 1'b1;
    end

    // Single step with start in the same cycle, then a stray start while busy
    fillMem();
    ready_force_en = 1'b1;
    ready_force = 1'b1;
    setMode(1'b1);
    beginDump();
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    hi = 0;
    while (debug_step && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("step_high_cycles", hi, 4);
    lo = 0;
    while (!debug_step && !tx_valid && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    checkOutput("step_low_at_least_4", (lo >= 4), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitDone("stepdump", 5000);
    compareDump("stepdump");

    // Known word at address 5 under a random sink
    fillMem();
    mem[5] = 32'h12345678;
    ready_force_en = 1'b0;
    ready_pct = 60;
    setMode(1'b0);
    beginDump();
    applyStimulus(1'b1, 1'b0);
    waitDone("addr5dump", 8000);
    compareDump("addr5dump");
    word5 = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      idx = 5 * BPA + (BPA - 4) + k;
      if (idx < got_q.size()) checkOutput($sformatf("addr5_byte%0d", k), got_q[idx], word5[8*(3-k) +: 8]);
      else checkOutput($sformatf("addr5_byte%0d_present", k), 0, 1);
    end

    // Sink stalls for 10 cycles on the very first byte
    fillMem();
    ready_force_en = 1'b1;
    ready_force = 1'b0;
    beginDump();
    applyStimulus(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    checkOutput("stall_first_valid_seen", seen, 1);
    held = tx_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_valid_c%0d", i), tx_valid, 1);
      checkOutput($sformatf("stall_data_c%0d", i), tx_data, held);
    end
    ready_force = 1'b1;
    waitDone("stalldump", 5000);
    compareDump("stalldump");

    // Randomized dumps: mode, trigger and sink rate all vary
    for (int r = 0; r < 3; r++) begin
      fillMem();
      ready_force_en = 1'b0;
      ready_pct = $urandom_range(100, 30);
      setMode(1'($urandom_range(1, 0)));
      beginDump();
      if ($urandom_range(1, 0) == 1) applyStimulus(1'b0, 1'b1);
      else applyStimulus(1'b1, 1'b0);
      waitDone($sformatf("rand%0d", r), 12000);
      compareDump($sformatf("rand%0d", r));
    end

    // Reset in the middle of sending address 10
    fillMem();
    ready_force_en = 1'b1;
    ready_force = 1'b1;
    setMode(1'b0);
    beginDump();
    applyStimulus(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (debug_addr == 7'd10 && tx_valid) seen = 1'b1;
    end
    checkOutput("midsend_reached_addr10", seen, 1);
    #1 rst = 1'b0;
    #1 checkResetOuts("midsend_reset");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    got_q.delete();
    repeat (60) @(negedge clk);
    checkOutput("after_reset_no_bytes", got_q.size(), 0);
    checkOutput("after_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_scan_ctrl.md
DEBUG_SCAN_CTRL -- requirements
Module: debug_scan_ctrl

Interface
REQ-001 Parameter STEP_CYC, default 4: number of cycles debug_step is held high per single-step.
REQ-002 Parameter SETTLE_CYC, default 2: wait cycles between a debug_addr change and capture of debug_data.
REQ-003 Parameter LAST_ADDR, default 63: final debug address scanned, range 0..127.
REQ-004 clk  in  1  main clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 dbg_mode  in  1  request the core to run in debug (stepped) mode.
REQ-007 step_req  in  1  single-cycle pulse: advance the core one debug clock, then dump state.
REQ-008 start  in  1  single-cycle pulse: dump state without stepping.
REQ-009 debug_data  in  32  word returned by the core for the current debug_addr.
REQ-010 tx_ready  in  1  byte sink (UART TX) accepts tx_data this cycle when high with tx_valid.
REQ-011 debug_en  out  1  registered copy of dbg_mode, drives core debug enable.
REQ-012 debug_step  out  1  stepped debug clock to the core.
REQ-013 debug_addr  out  7  debug address to the core.
REQ-014 tx_data  out  8  byte to the sink.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when a dump completes.

Function
REQ-018 The FSM SHALL have states IDLE, STEP_HI, STEP_LO, SETTLE, LATCH, SEND, NEXT, TERM, DONE.
REQ-019 In IDLE, step_req with debug_en=1 SHALL go to STEP_HI; else start SHALL go to SETTLE with debug_addr=0; step_req with debug_en=0 SHALL be treated as start.
REQ-020 When step_req and start are both high in IDLE, step_req SHALL take priority; both are ignored outside IDLE.
REQ-021 STEP_HI SHALL hold debug_step=1 for STEP_CYC cycles, then STEP_LO SHALL hold debug_step=0 for STEP_CYC cycles, then go to SETTLE with debug_addr=0.
REQ-022 SETTLE SHALL last SETTLE_CYC cycles; LATCH SHALL capture debug_data into a 32-bit shift register in one cycle.
REQ-023 SEND SHALL emit the captured word as 4 bytes, MSB first; each byte is one tx_valid/tx_ready transfer.
REQ-024 tx_valid, once asserted, SHALL remain high and tx_data SHALL remain stable until a cycle with tx_ready=1; the next byte SHALL be presented no earlier than the following cycle.
REQ-025 After the last byte, NEXT SHALL go to TERM if debug_addr==LAST_ADDR, else increment debug_addr by 1 and return to SETTLE.
REQ-026 TERM SHALL emit byte 0x0A with the same handshake, then go to DONE; DONE SHALL pulse done for one cycle, return to IDLE, and hold debug_addr at LAST_ADDR.
REQ-027 debug_en SHALL follow dbg_mode with one cycle latency in all states; a change of dbg_mode during a dump SHALL NOT abort it.
REQ-028 debug_addr SHALL never exceed LAST_ADDR and SHALL not wrap during a dump.

Reset
REQ-029 While rst=0, all state SHALL clear immediately regardless of clk: state=IDLE, debug_en=0, debug_step=0, debug_addr=0, tx_data=0x00, tx_valid=0, busy=0, done=0.
REQ-030 Reset mid-dump or mid-step SHALL abandon the operation with no further bytes emitted; the first action after reset release SHALL be evaluated from IDLE.

Configuration
REQ-031 With macro DEBUG_SCAN_ADDR_HDR_EN defined, SEND SHALL precede each word with one header byte {1'b0, debug_addr}, giving 5 bytes per address.
REQ-032 Without DEBUG_SCAN_ADDR_HDR_EN, exactly 4 bytes per address SHALL be sent and no header logic SHALL exist.

Verification
REQ-033 Reset release, dbg_mode=1, step_req pulse, tx_ready=1 -> debug_step high 4 cycles, low 4 cycles; 64x4+1=257 bytes, last 0x0A; done pulses once.
REQ-034 debug_data=0x12345678 for addr 5, start, tx_ready=1 -> bytes 20..23 are 0x12,0x34,0x56,0x78.
REQ-035 tx_ready held 0 for 10 cycles at first byte -> tx_valid and tx_data stay constant for those 10 cycles; no byte lost or duplicated.
REQ-036 start and step_req same cycle with dbg_mode=1 -> STEP_HI entered; second start while busy -> ignored, byte count unchanged.
REQ-037 rst=0 asserted mid-SEND at addr 10 -> outputs at reset values before next clk edge; after release, no bytes until new start.
REQ-038 DEBUG_SCAN_ADDR_HDR_EN defined, start -> 321 bytes; byte 5 is 0x01, followed by addr-1 word MSB first.
